cv32e40p_hwloop_ctrl_n: RTL
===========================

Name: cv32e40p_hwloop_ctrl_n

Overview:
Parametrised hardware-loop register file and controller supporting N_HWLP nested loops (previous generation fixed at 2).
- Holds start/end/count per loop and detects end-of-body at the ID-stage PC.
- Generates the jump request and target, and decrements loop counters on retirement.
- Sits beside the ID stage; written by lp.* instructions and CSR writes, consumed by the IF prefetcher.

Parameters:
N_HWLP, 2, number of hardware loops (1..8); index 0 = innermost, highest priority
N_HWLP_BITS, $clog2(N_HWLP) (min 1), width of loop index
ADDR_WIDTH, 32, width of start/end/PC addresses
CNT_WIDTH, 32, width of loop counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
hwlp_we_i  in  3  write enables {cnt, end, start} for the loop selected by hwlp_regid_i
hwlp_regid_i  in  N_HWLP_BITS  loop index for writes
hwlp_start_data_i  in  ADDR_WIDTH  new start address
hwlp_end_data_i  in  ADDR_WIDTH  new end address (address of last body instruction)
hwlp_cnt_data_i  in  CNT_WIDTH  new iteration count
pc_id_i  in  ADDR_WIDTH  PC of instruction currently in ID
id_valid_i  in  1  ID instruction retires/advances this cycle
hwlp_clear_i  in  1  synchronous clear of all counters (debug/flush)
hwlp_jump_o  out  1  jump to loop start requested
hwlp_target_o  out  ADDR_WIDTH  jump target (start of selected loop)
hwlp_active_o  out  N_HWLP  per-loop cnt != 0
hwlp_start_o  out  N_HWLP*ADDR_WIDTH  packed start registers (CSR readback)
hwlp_end_o  out  N_HWLP*ADDR_WIDTH  packed end registers
hwlp_cnt_o  out  N_HWLP*CNT_WIDTH  packed counter registers

Behaviour:
- Reset (rst=1, async): all start/end/cnt = 0. hwlp_jump_o=0, hwlp_target_o=0, hwlp_active_o=0. Reset mid-loop aborts all loops immediately; no further jumps.
- Writes: on clk rising edge, each asserted bit of hwlp_we_i loads the corresponding register of loop hwlp_regid_i. Start/end stored with bits [1:0] forced to 0. hwlp_regid_i >= N_HWLP: write ignored.
- Match: loop i matches when cnt[i] != 0 and pc_id_i == end[i].
- Selection: lowest-index matching loop wins (sel). Combinational, same cycle.
- hwlp_jump_o = match(sel) && cnt[sel] > 1. hwlp_target_o = start[sel] when jumping, else 0. Jump is asserted regardless of id_valid_i; IF qualifies it.
- Decrement: on edge, if id_valid_i and match(sel), then cnt[sel] <= cnt[sel] - 1 (including the final 1 -> 0 pass, which falls through with no jump). Only sel decrements; outer loops sharing the same end address decrement on a later pass, after the inner loop reaches 0.
- cnt == 0: the loop is inactive and never matches, so no decrement and no underflow.
- Simultaneous write and decrement on the same loop: the write wins for the cnt field; the decrement is dropped. A write to a different loop and a decrement proceed in parallel.
- hwlp_clear_i: on edge, all cnt <= 0 (start/end kept). It has priority over writes and decrements.
- Latency: a written value affects match/jump from the next cycle. A decrement is visible the next cycle.
- hwlp_active_o[i] = (cnt[i] != 0), registered-path (derived from the flops).

Test Plan:
- Reset then idle: after rst deassert, all outputs 0; pc_id_i=0 with end=0 gives no jump, because cnt=0.
- Single loop: write loop0 start=0x100, end=0x10C, cnt=3. Pulse id_valid_i at pc=0x10C three times. Expect jump=1, target=0x100 on passes 1 and 2; jump=0 on pass 3; cnt sequence 3,2,1,0; active[0] falls after pass 3.
- Nested priority (N_HWLP=4): loop0 end=0x200 cnt=2 and loop1 end=0x200 cnt=2. First two retirements at 0x200 touch only loop0 (cnt0 2->1->0, loop1 stays 2). The next retirement selects loop1 (jump, cnt1=1).
- Write/decrement collision: loop0 cnt=5 at its end, id_valid_i=1, same-cycle write cnt=9 to loop0 -> cnt0=9 next cycle. Repeat with the write to loop1 -> cnt0=4 and loop1 loaded.
- Alignment and bad index: write end=0x10F -> readback 0x10C. Write with regid=N_HWLP -> no register changes.
- Clear and async reset mid-loop: hwlp_clear_i during active loops -> all cnt=0, jump=0 next cycle, start/end retained. rst asserted mid-cycle -> outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cv32e40p_hwloop_ctrl_n.sv
// Hardware-loop register file and controller for N_HWLP nested loops.
// Loop 0 is the innermost loop and has the highest priority when several
// loops share the same end address. The jump request and target are purely
// combinational from the registers and pc_id_i, so an asynchronous reset
// clears them at once, without waiting for a clock edge.
module cv32e40p_hwloop_ctrl_n #(
    parameter int unsigned N_HWLP      = 2,
    parameter int unsigned N_HWLP_BITS = (N_HWLP > 1) ? $clog2(N_HWLP) : 1,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   hwlp_we_i,
    input  logic [N_HWLP_BITS-1:0]       hwlp_regid_i,
    input  logic [ADDR_WIDTH-1:0]        hwlp_start_data_i,
    input  logic [ADDR_WIDTH-1:0]        hwlp_end_data_i,
    input  logic [CNT_WIDTH-1:0]         hwlp_cnt_data_i,
    input  logic [ADDR_WIDTH-1:0]        pc_id_i,
    input  logic                         id_valid_i,
    input  logic                         hwlp_clear_i,
    output logic                         hwlp_jump_o,
    output logic [ADDR_WIDTH-1:0]        hwlp_target_o,
    output logic [N_HWLP-1:0]            hwlp_active_o,
    output logic [N_HWLP*ADDR_WIDTH-1:0] hwlp_start_o,
    output logic [N_HWLP*ADDR_WIDTH-1:0] hwlp_end_o,
    output logic [N_HWLP*CNT_WIDTH-1:0]  hwlp_cnt_o
);

    logic [ADDR_WIDTH-1:0] start_q [N_HWLP];
    logic [ADDR_WIDTH-1:0] start_d [N_HWLP];
    logic [ADDR_WIDTH-1:0] end_q   [N_HWLP];
    logic [ADDR_WIDTH-1:0] end_d   [N_HWLP];
    logic [CNT_WIDTH-1:0]  cnt_q   [N_HWLP];
    logic [CNT_WIDTH-1:0]  cnt_d   [N_HWLP];

    logic [N_HWLP-1:0]     match;
    logic [N_HWLP-1:0]     sel_oh;
    logic                  sel_found;
    logic [CNT_WIDTH-1:0]  sel_cnt;
    logic [ADDR_WIDTH-1:0] sel_start;
    logic [ADDR_WIDTH-1:0] start_aligned;
    logic [ADDR_WIDTH-1:0] end_aligned;

    // Instruction addresses are word aligned, so the two LSBs are never stored.
    assign start_aligned = {hwlp_start_data_i[ADDR_WIDTH-1:2], 2'b00};
    assign end_aligned   = {hwlp_end_data_i[ADDR_WIDTH-1:2], 2'b00};

    // End-of-body detection and lowest-index priority selection (one-hot).
    always_comb begin
        match     = '0;
        sel_oh    = '0;
        sel_found = 1'b0;
        sel_cnt   = '0;
        sel_start = '0;
        for (int unsigned i = 0; i < N_HWLP; i++) begin
            match[i] = (cnt_q[i] != '0) && (pc_id_i == end_q[i]);
            if (match[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_oh[i] = 1'b1;
                sel_cnt   = cnt_q[i];
                sel_start = start_q[i];
            end
        end
    end

    // Jump back to start unless this is the last pass (cnt == 1 falls through).
    always_comb begin
        hwlp_jump_o   = sel_found && (sel_cnt > CNT_WIDTH'(1));
        hwlp_target_o = hwlp_jump_o ? sel_start : '0;
    end

    // Next register state: decrement, then writes override, then clear overrides all.
    always_comb begin
        for (int unsigned i = 0; i < N_HWLP; i++) begin
            start_d[i] = start_q[i];
            end_d[i]   = end_q[i];
            cnt_d[i]   = cnt_q[i];
            if (id_valid_i && sel_oh[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
            end
            // An out-of-range regid never equals any valid index, so it writes nothing.
            if (hwlp_regid_i == N_HWLP_BITS'(i)) begin
                if (hwlp_we_i[0]) start_d[i] = start_aligned;
                if (hwlp_we_i[1]) end_d[i]   = end_aligned;
                if (hwlp_we_i[2]) cnt_d[i]   = hwlp_cnt_data_i;
            end
            if (hwlp_clear_i) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Loop register file with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_HWLP; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_HWLP; i++) begin
                start_q[i] <= start_d[i];
                end_q[i]   <= end_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Readback packing and per-loop active flags straight from the registers.
    always_comb begin
        hwlp_active_o = '0;
        hwlp_start_o  = '0;
        hwlp_end_o    = '0;
        hwlp_cnt_o    = '0;
        for (int unsigned i = 0; i < N_HWLP; i++) begin
            hwlp_active_o[i]                       = (cnt_q[i] != '0);
            hwlp_start_o[i*ADDR_WIDTH +: ADDR_WIDTH] = start_q[i];
            hwlp_end_o[i*ADDR_WIDTH +: ADDR_WIDTH]   = end_q[i];
            hwlp_cnt_o[i*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[i];
        end
    end

endmodule
